// File: rtl/forward_path_scheduler_pkg.sv
// Shared types for the forward-path scheduler: FSM states, output targets
// and the width of the optional per-output packet counters.
package forward_path_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        TGT_X = 2'd0,
        TGT_N = 2'd1,
        TGT_S = 2'd2
    } target_t;

    localparam int unsigned STATS_WIDTH = 16;

endpackage

// File: rtl/forward_path_scheduler_rr.sv
// Two-way round-robin arbiter: favours the requester not granted last,
// pointer starts at A (req[0]) and only moves when a grant is accepted.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    logic prio_b;

    always_comb begin
        grant = '0;
        if (req[0] && (!req[1] || !prio_b)) begin
            grant[0] = 1'b1;
        end else if (req[1]) begin
            grant[1] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            prio_b <= 1'b0;
        end else if (accept) begin
            prio_b <= grant[0];
        end
    end

endmodule

// File: rtl/forward_path_scheduler.sv
// Forward-path scheduler: pulls packets from two input FIFOs (round-robin) and
// routes each to lateral/north/south. Optional counters: FORWARD_PATH_STATS_EN.
module forward_path_scheduler
    import forward_path_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DX_MSB     = 29,
    parameter int DX_LSB     = 21,
    parameter int DY_MSB     = 20,
    parameter int DY_LSB     = 12,
    parameter int ADD        = -1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] a_din,
    input  logic                  a_empty,
    output logic                  a_ren,
    input  logic [DATA_WIDTH-1:0] b_din,
    input  logic                  b_empty,
    output logic                  b_ren,
    output logic [DATA_WIDTH-1:0] x_dout,
    output logic                  x_wen,
    input  logic                  x_full,
    output logic [DX_LSB-1:0]     n_dout,
    output logic                  n_wen,
    input  logic                  n_full,
    output logic [DX_LSB-1:0]     s_dout,
    output logic                  s_wen,
    input  logic                  s_full
`ifdef FORWARD_PATH_STATS_EN
    ,
    output logic [STATS_WIDTH-1:0] cnt_x,
    output logic [STATS_WIDTH-1:0] cnt_n,
    output logic [STATS_WIDTH-1:0] cnt_s
`endif
);

    localparam int unsigned DXW = DX_MSB - DX_LSB + 1;
    localparam int unsigned DYW = DY_MSB - DY_LSB + 1;

    state_t                  state_q, state_d;
    target_t                 tgt;
    logic [DATA_WIDTH-1:0]   hold_q;
    logic                    src_b_q;
    logic [1:0]              req, grant;
    logic                    issue, tgt_full;
    logic [DXW-1:0]          dx, dx_next;
    logic signed [DYW-1:0]   dy;

    assign req = {~b_empty, ~a_empty};
    assign dx  = hold_q[DX_MSB:DX_LSB];
    assign dy  = hold_q[DY_MSB:DY_LSB];
    assign dx_next = dx + DXW'(ADD);

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .accept (issue),
        .grant  (grant)
    );

    always_comb begin
        if (dx != '0) begin
            tgt = TGT_X;
        end else if (dy < $signed(DYW'(0))) begin
            tgt = TGT_S;
        end else begin
            tgt = TGT_N;
        end
    end

    always_comb begin
        case (tgt)
            TGT_X:   tgt_full = x_full;
            TGT_N:   tgt_full = n_full;
            TGT_S:   tgt_full = s_full;
            default: tgt_full = 1'b1;
        endcase
    end

    always_comb begin
        x_dout = hold_q;
        x_dout[DX_MSB:DX_LSB] = dx_next;
    end

    assign n_dout = hold_q[DX_LSB-1:0];
    assign s_dout = hold_q[DX_LSB-1:0];

    // Strobes are gated by rst so a packet caught in flight by reset is
    // dropped without a write or an extra FIFO pop during the reset cycle.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        x_wen   = 1'b0;
        n_wen   = 1'b0;
        s_wen   = 1'b0;
        if (rst) begin
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        issue   = 1'b1;
                        state_d = FETCH;
                    end
                end
                FETCH: state_d = HOLD;
                HOLD: begin
                    if (!tgt_full) begin
                        x_wen   = (tgt == TGT_X);
                        n_wen   = (tgt == TGT_N);
                        s_wen   = (tgt == TGT_S);
                        issue   = |req;
                        state_d = (|req) ? FETCH : IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign a_ren = issue & grant[0];
    assign b_ren = issue & grant[1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            src_b_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (issue) begin
                src_b_q <= grant[1];
            end
            if (state_q == FETCH) begin
                hold_q <= src_b_q ? b_din : a_din;
            end
        end
    end

`ifdef FORWARD_PATH_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_x <= '0;
            cnt_n <= '0;
            cnt_s <= '0;
        end else begin
            if (x_wen && cnt_x != '1) cnt_x <= cnt_x + 1'b1;
            if (n_wen && cnt_n != '1) cnt_n <= cnt_n + 1'b1;
            if (s_wen && cnt_s != '1) cnt_s <= cnt_s + 1'b1;
        end
    end
`endif

endmodule
